cla_word_scheduler: RTL and testbench

CLA_WORD_SCHEDULER -- requirements
Module: cla_word_scheduler

---
 rtl/cla_word_scheduler.sv | 202 ++++++++++++++++++++
 tb/tb_cla_word_scheduler.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_word_scheduler.sv
// -----------------------------------------------------------------------------
// cla_word_scheduler
//
// Time-multiplexes one external NBIT-wide adder slice to perform W-bit
// additions (W = NBIT*NWORDS) for two requesters. A request is granted
// round-robin, its operands are latched, and the slice is stepped once per
// cycle from the least significant word upward. The carry ripples through a
// register between words. The finished sum is held until the consumer takes it.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   reqN_valid / reqN_ready    request handshake for requester N (N = 0, 1)
//   reqN_a, reqN_b, reqN_cin   W-bit operands and carry-in of requester N
//   slc_a, slc_b, slc_c        operand word and carry-in for the shared slice
//   slc_sum, slc_cout          combinational result of the shared slice
//   rsp_valid / rsp_ready      response handshake
//   rsp_id                     requester index of the response
//   rsp_sum, rsp_cout          W-bit sum and final carry-out
//   busy                       high whenever an operation is in flight or held
// -----------------------------------------------------------------------------
module cla_word_scheduler #(
  parameter int NBIT   = 4,
  parameter int NWORDS = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req0_valid,
  output logic                   req0_ready,
  input  logic [NBIT*NWORDS-1:0] req0_a,
  input  logic [NBIT*NWORDS-1:0] req0_b,
  input  logic                   req0_cin,
  input  logic                   req1_valid,
  output logic                   req1_ready,
  input  logic [NBIT*NWORDS-1:0] req1_a,
  input  logic [NBIT*NWORDS-1:0] req1_b,
  input  logic                   req1_cin,
  output logic [NBIT-1:0]        slc_a,
  output logic [NBIT-1:0]        slc_b,
  output logic                   slc_c,
  input  logic [NBIT-1:0]        slc_sum,
  input  logic                   slc_cout,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic                   rsp_id,
  output logic [NBIT*NWORDS-1:0] rsp_sum,
  output logic                   rsp_cout,
  output logic                   busy
);

  localparam int W  = NBIT * NWORDS;
  localparam int KW = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;

  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic          cin_q, cin_d;
  logic          id_q, id_d;
  logic          last_grant_q, last_grant_d;
  logic [KW-1:0] k_q, k_d;
  logic          carry_q, carry_d;
  logic [W-1:0]  sum_q, sum_d;
  logic          cout_q, cout_d;

  logic          grant;
  logic          accept;
  logic          last_word;

  // Round-robin arbitration: a lone requester always wins; on a tie the one
  // that was not served last time wins.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) begin
      grant = ~last_grant_q;
    end else if (req1_valid) begin
      grant = 1'b1;
    end
  end

  assign accept    = req0_ready | req1_ready;
  assign last_word = (k_q == KW'(NWORDS - 1));

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the values that were present before the clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: each combinational output gets a default before any branch; a path
  // that leaves it unassigned would infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept)                state_d = RUN;
      RUN:     if (last_word)             state_d = DONE;
      DONE:    if (rsp_ready)             state_d = IDLE;
      default:                            state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    // Ready is gated by rst_n so no handshake can be seen while reset is held.
    req0_ready = rst_n && (state_q == IDLE) && req0_valid && !grant;
    req1_ready = rst_n && (state_q == IDLE) && req1_valid &&  grant;
    busy       = (state_q != IDLE);
    rsp_valid  = (state_q == DONE);
    slc_a      = '0;
    slc_b      = '0;
    slc_c      = 1'b0;
    if (state_q == RUN) begin
      slc_a = a_q[k_q*NBIT +: NBIT];
      slc_b = b_q[k_q*NBIT +: NBIT];
      // Word 0 takes the request's carry-in; later words take the carry
      // produced by the slice on the previous cycle.
      slc_c = (k_q == '0) ? cin_q : carry_q;
    end
  end

  assign rsp_id   = id_q;
  assign rsp_sum  = sum_q;
  assign rsp_cout = cout_q;

  // ---------------------------------------------------------------------------
  // Datapath next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    a_d          = a_q;
    b_d          = b_q;
    cin_d        = cin_q;
    id_d         = id_q;
    last_grant_d = last_grant_q;
    k_d          = k_q;
    carry_d      = carry_q;
    sum_d        = sum_q;
    cout_d       = cout_q;

    if (state_q == IDLE && accept) begin
      a_d          = grant ? req1_a   : req0_a;
      b_d          = grant ? req1_b   : req0_b;
      cin_d        = grant ? req1_cin : req0_cin;
      id_d         = grant;
      last_grant_d = grant;
      k_d          = '0;
    end else if (state_q == RUN) begin
      sum_d[k_q*NBIT +: NBIT] = slc_sum;
      carry_d                 = slc_cout;
      k_d                     = last_word ? '0 : k_q + 1'b1;
      if (last_word) begin
        cout_d = slc_cout;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  // NOTE: the operand registers are reset too; they are few, and it keeps the
  // slice inputs and response outputs free of X after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q          <= '0;
      b_q          <= '0;
      cin_q        <= 1'b0;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;
      k_q          <= '0;
      carry_q      <= 1'b0;
      sum_q        <= '0;
      cout_q       <= 1'b0;
    end else begin
      a_q          <= a_d;
      b_q          <= b_d;
      cin_q        <= cin_d;
      id_q         <= id_d;
      last_grant_q <= last_grant_d;
      k_q          <= k_d;
      carry_q      <= carry_d;
      sum_q        <= sum_d;
      cout_q       <= cout_d;
    end
  end

endmodule

// File: tb/tb_cla_word_scheduler.sv
// -----------------------------------------------------------------------------
// tb_cla_word_scheduler
//
// Bench for cla_word_scheduler with NBIT=4, NWORDS=4. A 4-bit adder model plays
// the shared slice. Directed vectors are held in a table; arbitration, response
// back-pressure and reset abort are written out as sequences; a random phase
// compares every response against a+b+cin kept in a scoreboard queue.
// -----------------------------------------------------------------------------
module tb_cla_word_scheduler;

  localparam int NBIT   = 4;
  localparam int NWORDS = 4;
  localparam int W      = NBIT * NWORDS;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0_valid, req0_ready, req0_cin;
  logic          req1_valid, req1_ready, req1_cin;
  logic [W-1:0]  req0_a, req0_b, req1_a, req1_b;
  logic [NBIT-1:0] slc_a, slc_b, slc_sum;
  logic          slc_c, slc_cout;
  logic          rsp_valid, rsp_ready, rsp_id, rsp_cout, busy;
  logic [W-1:0]  rsp_sum;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Shared slice: plain NBIT-bit adder.
  assign {slc_cout, slc_sum} = {1'b0, slc_a} + {1'b0, slc_b} + {{NBIT{1'b0}}, slc_c};

  cla_word_scheduler #(.NBIT(NBIT), .NWORDS(NWORDS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_cin   (req0_cin),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_cin   (req1_cin),
    .slc_a      (slc_a),
    .slc_b      (slc_b),
    .slc_c      (slc_c),
    .slc_sum    (slc_sum),
    .slc_cout   (slc_cout),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_sum    (rsp_sum),
    .rsp_cout   (rsp_cout),
    .busy       (busy)
  );

  typedef struct {
    logic         id;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
  } vec_t;

  typedef struct {
    logic         id;
    logic [W-1:0] sum;
    logic         cout;
  } exp_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_cin = 1'b0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_cin = 1'b0;
    rsp_ready  = 1'b0;
  endtask

  task automatic scramble_operands();
    req0_a = W'($urandom); req0_b = W'($urandom); req0_cin = 1'($urandom);
    req1_a = W'($urandom); req1_b = W'($urandom); req1_cin = 1'($urandom);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Issues one request from a single requester and checks latency and result.
  task automatic do_op(input int idx, input vec_t v);
    int  n;
    logic rdy;
    @(negedge clk);
    if (v.id == 1'b0) begin
      req0_valid = 1'b1; req0_a = v.a; req0_b = v.b; req0_cin = v.cin;
    end else begin
      req1_valid = 1'b1; req1_a = v.a; req1_b = v.b; req1_cin = v.cin;
    end
    #1;
    n = 0;
    rdy = v.id ? req1_ready : req0_ready;
    while (!rdy && n < 10) begin
      @(negedge clk); #1;
      n++;
      rdy = v.id ? req1_ready : req0_ready;
    end
    check($sformatf("vec%0d_ready", idx), 64'(rdy), 64'(1));
    if (!rdy) begin
      req0_valid = 1'b0; req1_valid = 1'b0;
      return;
    end
    @(negedge clk);
    // First RUN cycle: word 0 gets the request's own carry-in.
    check($sformatf("vec%0d_first_slc_c", idx), 64'(slc_c), 64'(v.cin));
    req0_valid = 1'b0; req1_valid = 1'b0;
    scramble_operands();
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      scramble_operands();
      n++;
    end
    check($sformatf("vec%0d_latency", idx), 64'(n), 64'(NWORDS));
    check($sformatf("vec%0d_sum", idx), 64'(rsp_sum), 64'(v.exp_sum));
    check($sformatf("vec%0d_cout_id", idx), 64'({rsp_cout, rsp_id}), 64'({v.exp_cout, v.id}));
    rsp_ready = 1'b1;
    @(negedge clk);
    check($sformatf("vec%0d_release", idx), 64'({rsp_valid, busy}), 64'(0));
    rsp_ready = 1'b0;
  endtask

  function automatic logic [W-1:0] rand_word();
    int sel;
    sel = $urandom_range(0, 7);
    if (sel == 0) return '0;
    if (sel == 1) return '1;
    return W'($urandom);
  endfunction

  vec_t vecs[8];
  exp_t sb[$];

  initial begin
    // id, a, b, cin, expected sum, expected cout (hand-computed)
    vecs[0] = '{1'b0, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0};
    vecs[1] = '{1'b1, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1};
    vecs[2] = '{1'b0, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0};
    vecs[3] = '{1'b1, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
    vecs[4] = '{1'b0, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
    vecs[5] = '{1'b1, 16'h0F0F, 16'hF0F0, 1'b1, 16'h0000, 1'b1};
    vecs[6] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
    vecs[7] = '{1'b1, 16'hABCD, 16'h1111, 1'b0, 16'hBCDE, 1'b0};

    idle_inputs();
    rst_n = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    // Reset state, with both requesters asserting valid.
    check("rst_ready", 64'({req0_ready, req1_ready}), 64'(0));
    check("rst_rsp", 64'({rsp_valid, rsp_id, rsp_cout, busy}), 64'(0));
    check("rst_sum", 64'(rsp_sum), 64'(0));
    check("rst_slc", 64'({slc_a, slc_b, slc_c}), 64'(0));

    // ---- Arbitration: both valid from reset release, consumer always ready.
    begin
      int   grants[4];
      int   gcyc[4];
      int   ng;
      logic prev_rdy;
      rsp_ready = 1'b1;
      req0_a = 16'h0001; req0_b = 16'h0002;
      req1_a = 16'h0010; req1_b = 16'h0020;
      rst_n = 1'b1;
      ng = 0;
      prev_rdy = 1'b0;
      for (int c = 0; c < 60 && ng < 4; c++) begin
        #1;
        if (req0_ready && req1_ready) check("rr_both_ready", 64'(1), 64'(0));
        if (req0_ready || req1_ready) begin
          if (prev_rdy) check("rr_ready_one_cycle", 64'(1), 64'(0));
          grants[ng] = req1_ready ? 1 : 0;
          gcyc[ng]   = c;
          ng++;
        end
        prev_rdy = req0_ready | req1_ready;
        @(negedge clk);
      end
      check("rr_grant_count", 64'(ng), 64'(4));
      for (int i = 0; i < ng; i++) begin
        check($sformatf("rr_grant%0d", i), 64'(grants[i]), 64'(i % 2));
        if (i > 0) check($sformatf("rr_interval%0d", i), 64'(gcyc[i] - gcyc[i-1]), 64'(NWORDS + 2));
      end
      idle_inputs();
    end
    apply_reset();

    // ---- Directed vectors.
    for (int i = 0; i < 8; i++) do_op(i, vecs[i]);

    // ---- Back-pressure in DONE: outputs hold, no ready, then release.
    begin
      int   n;
      logic [W-1:0] s;
      logic c, id;
      @(negedge clk);
      req0_valid = 1'b1; req0_a = 16'h1111; req0_b = 16'h2222; req0_cin = 1'b1;
      #1;
      check("bp_ready", 64'(req0_ready), 64'(1));
      @(negedge clk);
      req0_valid = 1'b0;
      n = 0;
      while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
      check("bp_latency", 64'(n), 64'(NWORDS));
      check("bp_result", 64'({rsp_cout, rsp_id, rsp_sum}), 64'({1'b0, 1'b0, 16'h3334}));
      s = rsp_sum; c = rsp_cout; id = rsp_id;
      req0_valid = 1'b1; req1_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
        scramble_operands();
        @(negedge clk);
        check($sformatf("bp_hold%0d", i), 64'({rsp_valid, rsp_cout, rsp_id, rsp_sum}), 64'({1'b1, c, id, s}));
        check($sformatf("bp_noready%0d", i), 64'({req0_ready, req1_ready}), 64'(0));
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      #1;
      check("bp_back_idle", 64'({rsp_valid, busy}), 64'(0));
      // Last grant was 0, so the tie now goes to requester 1.
      check("bp_idle_grant", 64'({req0_ready, req1_ready}), 64'(2'b01));
      req0_valid = 1'b0; req1_valid = 1'b0;
    end
    apply_reset();

    // ---- Reset while in RUN at k=2 aborts the operation.
    begin
      logic seen;
      @(negedge clk);
      req1_valid = 1'b1; req1_a = 16'h00FF; req1_b = 16'h0F00; req1_cin = 1'b0;
      #1;
      check("ra_ready", 64'(req1_ready), 64'(1));
      @(negedge clk);   // RUN, k=0
      req1_valid = 1'b0;
      @(negedge clk);   // k=1
      @(negedge clk);   // k=2
      check("ra_busy_before", 64'(busy), 64'(1));
      rst_n = 1'b0;
      #1;
      check("ra_async", 64'({busy, rsp_valid}), 64'(0));
      check("ra_slc", 64'({slc_a, slc_b, slc_c}), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;
      rsp_ready = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
        @(negedge clk);
        if (rsp_valid || busy) seen = 1'b1;
      end
      check("ra_no_response", 64'(seen), 64'(0));
      rsp_ready = 1'b0;
    end

    // ---- Random traffic against a scoreboard.
    begin
      int   accepts, rsps, cyc;
      logic acc0, acc1, issue;
      exp_t e, got;
      accepts = 0; rsps = 0; cyc = 0;
      acc0 = 1'b0; acc1 = 1'b0;
      while ((accepts < 1000 || sb.size() > 0) && cyc < 40000) begin
        @(negedge clk);
        cyc++;
        issue = (accepts < 1000);
        if (acc0) req0_valid = 1'b0;
        if (acc1) req1_valid = 1'b0;
        if (req0_valid) begin
          if ($urandom_range(0, 15) == 0) req0_valid = 1'b0;
        end else if (issue && $urandom_range(0, 1) == 1) begin
          req0_valid = 1'b1; req0_a = rand_word(); req0_b = rand_word(); req0_cin = 1'($urandom);
        end
        if (req1_valid) begin
          if ($urandom_range(0, 15) == 0) req1_valid = 1'b0;
        end else if (issue && $urandom_range(0, 1) == 1) begin
          req1_valid = 1'b1; req1_a = rand_word(); req1_b = rand_word(); req1_cin = 1'($urandom);
        end
        rsp_ready = issue ? 1'($urandom) : 1'b1;
        #4;
        if (req0_ready && req1_ready) check("rnd_both_ready", 64'(1), 64'(0));
        acc0 = req0_valid && req0_ready;
        acc1 = req1_valid && req1_ready;
        if (acc0) begin
          e.id = 1'b0;
          {e.cout, e.sum} = {1'b0, req0_a} + {1'b0, req0_b} + {{W{1'b0}}, req0_cin};
          sb.push_back(e);
          accepts++;
        end
        if (acc1) begin
          e.id = 1'b1;
          {e.cout, e.sum} = {1'b0, req1_a} + {1'b0, req1_b} + {{W{1'b0}}, req1_cin};
          sb.push_back(e);
          accepts++;
        end
        if (rsp_valid && rsp_ready) begin
          rsps++;
          if (sb.size() == 0) begin
            check("rnd_spurious_rsp", 64'(1), 64'(0));
          end else begin
            got = sb.pop_front();
            check($sformatf("rnd_rsp%0d", rsps), 64'({rsp_id, rsp_cout, rsp_sum}), 64'({got.id, got.cout, got.sum}));
          end
        end
        if (!issue) begin
          req0_valid = 1'b0; req1_valid = 1'b0;
        end
      end
      check("rnd_accepts_done", 64'(accepts >= 1000), 64'(1));
      check("rnd_one_rsp_per_accept", 64'(rsps), 64'(accepts));
      check("rnd_sb_empty", 64'(sb.size()), 64'(0));
    end

    idle_inputs();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
